// File: rtl/mem_arbiter.sv
// Two-requester (Icache/Dcache) arbiter onto a single tagged memory port with load-tag tracking.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed Dcache priority.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int unsigned NUM_TAGS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [`XLEN-1:0]  ic_req_addr,
  output logic              ic_grant,
  output logic              ic_data_valid,
  output logic [63:0]       ic_data,
  output logic [3:0]        ic_data_tag,
  input  logic              dc_req_valid,
  input  logic [1:0]        dc_req_cmd,
  input  logic [`XLEN-1:0]  dc_req_addr,
  input  logic [63:0]       dc_req_data,
  output logic              dc_grant,
  output logic              dc_data_valid,
  output logic [63:0]       dc_data,
  output logic [3:0]        dc_data_tag,
  output logic [3:0]        ic_resp_tag,
  output logic [3:0]        dc_resp_tag,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag,
  output logic              arb_err
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // Owner table: owner bit 1 = Dcache, 0 = Icache.
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;
  logic                err_q, err_d;
  logic                ic_sel, dc_sel;
  logic                accepted, alloc, alloc_ok, ret_ok, ret_hit, ret_miss;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;  // 0 = Icache's turn, 1 = Dcache's turn
`endif

  always_comb begin
    ic_sel = 1'b0;
    dc_sel = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (ic_req_valid && dc_req_valid) begin
        dc_sel = ptr_q;
        ic_sel = ~ptr_q;
      end else begin
        ic_sel = ic_req_valid;
        dc_sel = dc_req_valid;
      end
`else
      dc_sel = dc_req_valid;
      ic_sel = ic_req_valid & ~dc_req_valid;
`endif
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (dc_sel) begin
      proc2mem_command = dc_req_cmd;
      proc2mem_addr    = dc_req_addr;
      if (dc_req_cmd == BUS_STORE) proc2mem_data = dc_req_data;
    end else if (ic_sel) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ic_req_addr;
    end
  end

  assign accepted    = mem2proc_response != 4'd0;
  assign ic_grant    = ic_sel & accepted;
  assign dc_grant    = dc_sel & accepted;
  assign ic_resp_tag = ic_grant ? mem2proc_response : 4'd0;
  assign dc_resp_tag = dc_grant ? mem2proc_response : 4'd0;

  assign alloc_ok = 32'(mem2proc_response) < NUM_TAGS;
  assign alloc    = alloc_ok & (ic_grant | (dc_grant & (dc_req_cmd == BUS_LOAD)));

  assign ret_ok   = (mem2proc_tag != 4'd0) && (32'(mem2proc_tag) < NUM_TAGS);
  assign ret_hit  = !reset && ret_ok && valid_q[mem2proc_tag];
  assign ret_miss = !reset && (mem2proc_tag != 4'd0) && !(ret_ok && valid_q[mem2proc_tag]);

  assign ic_data_valid = ret_hit & ~owner_q[mem2proc_tag];
  assign dc_data_valid = ret_hit & owner_q[mem2proc_tag];
  assign ic_data       = mem2proc_data;
  assign dc_data       = mem2proc_data;
  assign ic_data_tag   = mem2proc_tag;
  assign dc_data_tag   = mem2proc_tag;
  assign arb_err       = err_q;

  // Clear on return first so a same-cycle allocation of that tag wins.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    err_d   = err_q | ret_miss;
    if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = dc_grant;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (ic_grant) ptr_d = 1'b1;
    if (dc_grant) ptr_d = 1'b0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      err_q   <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations track MEM_ARB_ROUND_ROBIN_EN.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;
  logic             clock = 1'b0;
  logic             reset;
  logic             ic_req_valid;
  logic [`XLEN-1:0] ic_req_addr;
  logic             ic_grant, ic_data_valid;
  logic [63:0]      ic_data;
  logic [3:0]       ic_data_tag;
  logic             dc_req_valid;
  logic [1:0]       dc_req_cmd;
  logic [`XLEN-1:0] dc_req_addr;
  logic [63:0]      dc_req_data;
  logic             dc_grant, dc_data_valid;
  logic [63:0]      dc_data;
  logic [3:0]       dc_data_tag;
  logic [3:0]       ic_resp_tag, dc_resp_tag;
  logic [1:0]       proc2mem_command;
  logic [`XLEN-1:0] proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [3:0]       mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [3:0]       mem2proc_tag;
  logic             arb_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NUM_TAGS(16)) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_grant(ic_grant),
    .ic_data_valid(ic_data_valid), .ic_data(ic_data), .ic_data_tag(ic_data_tag),
    .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_grant(dc_grant), .dc_data_valid(dc_data_valid),
    .dc_data(dc_data), .dc_data_tag(dc_data_tag),
    .ic_resp_tag(ic_resp_tag), .dc_resp_tag(dc_resp_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag), .arb_err(arb_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_cmd = 2'd0; dc_req_addr = '0; dc_req_data = '0;
    mem2proc_response = 4'd0; mem2proc_data = '0; mem2proc_tag = 4'd0;
  endtask

  // Inputs change 1 time unit after a rising edge; combinational checks 2 units later.
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Outputs stay quiet during reset even with live request/return inputs.
    ic_req_valid = 1'b1; mem2proc_response = 4'd3; mem2proc_tag = 4'd1;
    settle();
    chk("rst_ic_grant", 64'(ic_grant), 64'd0);
    chk("rst_cmd", 64'(proc2mem_command), 64'd0);
    chk("rst_ic_resp_tag", 64'(ic_resp_tag), 64'd0);
    chk("rst_ic_dv", 64'(ic_data_valid), 64'd0);
    chk("rst_dc_dv", 64'(dc_data_valid), 64'd0);
    tick(); tick();
    chk("rst_arb_err", 64'(arb_err), 64'd0);
    idle(); reset = 1'b0;
    tick();

    // Icache load accepted with tag 3, data returns 5 cycles later.
    ic_req_valid = 1'b1; ic_req_addr = 'h40; mem2proc_response = 4'd3;
    settle();
    chk("ld_ic_grant", 64'(ic_grant), 64'd1);
    chk("ld_ic_resp_tag", 64'(ic_resp_tag), 64'd3);
    chk("ld_cmd", 64'(proc2mem_command), 64'd1);
    chk("ld_addr", 64'(proc2mem_addr), 64'h40);
    chk("ld_data0", proc2mem_data, 64'd0);
    chk("ld_dc_grant", 64'(dc_grant), 64'd0);
    tick(); idle();
    repeat (4) tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hAABBCCDD11223344;
    settle();
    chk("ret_ic_dv", 64'(ic_data_valid), 64'd1);
    chk("ret_ic_data", ic_data, 64'hAABBCCDD11223344);
    chk("ret_ic_tag", 64'(ic_data_tag), 64'd3);
    chk("ret_dc_dv", 64'(dc_data_valid), 64'd0);
    tick(); idle();
    chk("ret_no_err", 64'(arb_err), 64'd0);

    // Contention from a fresh reset, response 1 every cycle.
    reset = 1'b1; tick(); reset = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 'h80;
    dc_req_valid = 1'b1; dc_req_cmd = 2'd1; dc_req_addr = 'h200;
    mem2proc_response = 4'd1;
    for (int i = 0; i < 3; i++) begin
      settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("cont_ic_grant", 64'(ic_grant), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("cont_dc_grant", 64'(dc_grant), (i % 2 == 1) ? 64'd1 : 64'd0);
      chk("cont_addr", 64'(proc2mem_addr), (i % 2 == 0) ? 64'h80 : 64'h200);
`else
      chk("cont_ic_grant", 64'(ic_grant), 64'd0);
      chk("cont_dc_grant", 64'(dc_grant), 64'd1);
      chk("cont_addr", 64'(proc2mem_addr), 64'h200);
`endif
      tick();
    end

    // Rejected cycle: no grants, and arbitration state must not move.
    mem2proc_response = 4'd0;
    settle();
    chk("rej_ic_grant", 64'(ic_grant), 64'd0);
    chk("rej_dc_grant", 64'(dc_grant), 64'd0);
    tick();
    mem2proc_response = 4'd1;
    settle();
    // Round-robin: last grant was IC, so DC's turn persists across the reject.
    chk("rej_next_dc_grant", 64'(dc_grant), 64'd1);
    chk("rej_next_ic_grant", 64'(ic_grant), 64'd0);
    tick(); idle();
    mem2proc_tag = 4'd1; mem2proc_data = 64'h55;
    settle();
    chk("t1_dc_dv", 64'(dc_data_valid), 64'd1);
    chk("t1_ic_dv", 64'(ic_data_valid), 64'd0);
    chk("t1_dc_tag", 64'(dc_data_tag), 64'd1);
    tick(); idle();

    // Store is granted but never tracked; its tag coming back is an error.
    dc_req_valid = 1'b1; dc_req_cmd = 2'd2; dc_req_addr = 'h100; dc_req_data = 64'h1234;
    mem2proc_response = 4'd2;
    settle();
    chk("st_dc_grant", 64'(dc_grant), 64'd1);
    chk("st_cmd", 64'(proc2mem_command), 64'd2);
    chk("st_addr", 64'(proc2mem_addr), 64'h100);
    chk("st_data", proc2mem_data, 64'h1234);
    chk("st_resp_tag", 64'(dc_resp_tag), 64'd2);
    tick(); idle(); tick();
    mem2proc_tag = 4'd2;
    settle();
    chk("st_ret_ic_dv", 64'(ic_data_valid), 64'd0);
    chk("st_ret_dc_dv", 64'(dc_data_valid), 64'd0);
    tick(); idle();
    chk("st_err_set", 64'(arb_err), 64'd1);
    repeat (2) tick();
    chk("st_err_sticky", 64'(arb_err), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("err_cleared", 64'(arb_err), 64'd0);

    // Same-cycle return and reallocation of tag 4.
    ic_req_valid = 1'b1; ic_req_addr = 'h300; mem2proc_response = 4'd4;
    tick(); idle();
    dc_req_valid = 1'b1; dc_req_cmd = 2'd1; dc_req_addr = 'h400; mem2proc_response = 4'd4;
    mem2proc_tag = 4'd4; mem2proc_data = 64'h0123456789ABCDEF;
    settle();
    chk("same_ic_dv", 64'(ic_data_valid), 64'd1);
    chk("same_dc_dv", 64'(dc_data_valid), 64'd0);
    chk("same_dc_grant", 64'(dc_grant), 64'd1);
    tick(); idle();
    mem2proc_tag = 4'd4; mem2proc_data = 64'hFEDCBA9876543210;
    settle();
    chk("realloc_dc_dv", 64'(dc_data_valid), 64'd1);
    chk("realloc_ic_dv", 64'(ic_data_valid), 64'd0);
    chk("realloc_dc_data", dc_data, 64'hFEDCBA9876543210);
    tick(); idle();
    chk("realloc_no_err", 64'(arb_err), 64'd0);

    // Reset drops outstanding tags 1 and 2.
    ic_req_valid = 1'b1; ic_req_addr = 'h500; mem2proc_response = 4'd1;
    tick(); idle();
    dc_req_valid = 1'b1; dc_req_cmd = 2'd1; dc_req_addr = 'h600; mem2proc_response = 4'd2;
    tick(); idle();
    reset = 1'b1; tick(); reset = 1'b0;
    mem2proc_tag = 4'd1;
    settle();
    chk("post_rst_ic_dv", 64'(ic_data_valid), 64'd0);
    chk("post_rst_dc_dv", 64'(dc_data_valid), 64'd0);
    tick(); idle();
    chk("post_rst_err", 64'(arb_err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_TAGS, default 16, number of memory transaction tags (tag 0 = none); tag width 4 bits.
REQ-002 clock  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ic_req_valid  in  1  Icache refill load request; ic_req_addr  in  `XLEN  load address.
REQ-005 ic_grant  out  1  Icache request accepted by memory this cycle.
REQ-006 ic_data_valid  out  1  return data for Icache; ic_data  out  64  data; ic_data_tag  out  4  matching tag.
REQ-007 dc_req_valid  in  1; dc_req_cmd  in  2 (BUS_LOAD/BUS_STORE); dc_req_addr  in  `XLEN; dc_req_data  in  64  store data.
REQ-008 dc_grant  out  1; dc_data_valid  out  1; dc_data  out  64; dc_data_tag  out  4  Dcache equivalents of REQ-005/006.
REQ-009 ic_resp_tag, dc_resp_tag  out  4  memory response tag forwarded to the granted requester, 0 otherwise.
REQ-010 proc2mem_command  out  2; proc2mem_addr  out  `XLEN; proc2mem_data  out  64  single memory port.
REQ-011 mem2proc_response  in  4  accept tag (0 = rejected); mem2proc_data  in  64; mem2proc_tag  in  4  returning load tag.
REQ-012 arb_err  out  1  sticky: data returned with untracked tag.

Function
REQ-013 Each cycle, combinationally select at most one requester; drive its command/addr/data to memory; drive BUS_NONE, addr 0, data 0 when none.
REQ-014 Icache requests always issue BUS_LOAD; proc2mem_data = 0 for loads.
REQ-015 Grant to selected requester = selected AND mem2proc_response != 0; non-selected requester grant = 0 (requester retries, holding inputs stable).
REQ-016 On granted load, record owner table[mem2proc_response] = {valid=1, owner=IC/DC} at next edge; granted stores record nothing.
REQ-017 When mem2proc_tag != 0 and table[tag].valid: assert owner's data_valid same cycle, with mem2proc_data and tag; clear entry at edge.
REQ-018 Return with mem2proc_tag != 0 and invalid entry: no data_valid asserted, arb_err set, held until reset.
REQ-019 Same tag returned and re-allocated in one cycle: allocation wins; entry ends valid with new owner.
REQ-020 Return path independent of request path: a return and a new grant may occur in the same cycle for either requester.
REQ-021 Latency: request-to-grant 0 cycles when selected and accepted; tag-to-data_valid 0 cycles.
REQ-022 Rejected request (response 0) does not update arbitration state.

Reset
REQ-023 At reset: owner table all invalid, arb_err = 0, round-robin pointer = Icache.
REQ-024 While reset high: grants 0, data_valid 0, proc2mem_command BUS_NONE, resp tags 0.
REQ-025 Reset mid-transaction discards all outstanding tags; later returns of those tags set arb_err.

Configuration
REQ-026 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both request, select pointer's requester; pointer flips to the other requester after each accepted grant.
REQ-027 Macro undefined: fixed priority, Dcache always wins contention; no pointer state.

Verification
REQ-028 Reset, then ic_req_valid=1 addr 0x40, response=3 -> ic_grant=1, ic_resp_tag=3, command BUS_LOAD; tag 3 returned 5 cycles later with data 0xAABBCCDD11223344 -> ic_data_valid=1, dc_data_valid=0.
REQ-029 Both request, response=1 each cycle: round-robin build -> grants alternate IC,DC,IC; fixed build -> DC granted every cycle, ic_grant=0.
REQ-030 dc store addr 0x100 data 0x1234, response=2 -> dc_grant=1, BUS_STORE, no table entry; later mem2proc_tag=2 -> arb_err=1, no data_valid.
REQ-031 response=0 with both requesting -> no grants, round-robin pointer unchanged next cycle.
REQ-032 Outstanding IC tag 4; same cycle mem2proc_tag=4 and DC load granted with response=4 -> ic_data_valid=1; next return of tag 4 -> dc_data_valid=1.
REQ-033 Assert reset with tags 1,2 outstanding -> after reset, return of tag 1 -> arb_err=1, both data_valid=0.
